// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard logic
package hazard_pkg;

    // Sequencer state, 2-bit encoded
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INST   = 32'h00000013;

    // Major opcodes shared with instruction-decode users
    localparam logic [6:0]  OP_LOAD    = 7'b0000011;
    localparam logic [6:0]  OP_JAL     = 7'b1101111;
    localparam logic [6:0]  OP_JALR    = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection
//
// Ports:
//   id_rs1, id_rs2         source register fields of the instruction in ID
//   id_use_rs1, id_use_rs2 the ID instruction actually reads that source
//   ex_rd                  destination register of the instruction in EX
//   ex_is_load             EX instruction is a load
//   lu                     load-use hazard: ID needs a value the EX load has not produced yet
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign lu = ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush sequencer for the 5-stage RV32I pipeline
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   id_rs1/id_rs2/id_use_*   ID-stage source operands and their use flags
//   ex_rd, ex_is_load        EX-stage destination and load flag
//   ex_redirect              EX branch taken / jump; PC loads target next edge
//   mem_req, mem_ready       data-memory handshake of the MEM stage
//   pc_en, ifid_en, idex_en, exmem_en   pipeline register enables
//   ifid_flush, idex_flush   load NOP into IF/ID, ID/EX
//   mem_timeout              sticky flag: memory never answered
//   stall_cycles             saturating count of cycles with pc_en=0
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TCNT_W  = 7,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [TCNT_W-1:0] WAIT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic [TCNT_W-1:0]   wait_cnt, wait_nxt;
    logic                timeout_q, timeout_nxt;
    logic [PERF_W-1:0]   stall_q;
    logic                lu;
    logic                mw;
    logic                issue;

    hazard_detect u_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .lu         (lu)
    );

    assign mw = mem_req && !mem_ready;

    // Cycles in which the normal redirect / load-use rules govern the pipeline:
    // RUN without a memory wait, and the release cycle out of MEM_WAIT.
    // Redirect and load-use that arrived while frozen are still present
    // (EX/ID were held), so they are serviced here.
    assign issue = rst && (((state == ST_RUN) && !mw) ||
                           ((state == ST_MEM_WAIT) && mem_ready));

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (issue) begin
            if (ex_redirect) begin
                // The ID instruction is squashed, so any load-use on it is moot
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu) begin
                // Hold IF/ID, send one bubble into EX, let the load advance
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                idex_flush = 1'b1;
            end else begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_nxt = timeout_q;
        case (state)
            ST_RUN: begin
                if (mw) begin
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = TCNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = ST_ERROR;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + TCNT_W'(1);
                end
            end
            ST_ERROR: begin
                // Only reset leaves this state
            end
            default: begin
                state_nxt = ST_RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            timeout_q <= timeout_nxt;
            if (!pc_en && (stall_q != {PERF_W{1'b1}})) begin
                stall_q <= stall_q + PERF_W'(1);
            end
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three hazard classes: load-use, taken branch/jump redirect out of EX, and a multi-cycle data-memory wait handshake.
- Counts stall cycles and latches a sticky timeout flag when memory never answers.

Parameters:
TIMEOUT, 64, number of consecutive memory-wait cycles after which the ERROR state is entered.
TCNT_W, 7, width of the wait counter. Must satisfy 2^TCNT_W > TIMEOUT.
PERF_W, 32, width of the saturating stall-cycle performance counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-low
id_rs1  in  5  rs1 field of the instruction in ID
id_rs2  in  5  rs2 field of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd field of the instruction in EX
ex_is_load  in  1  EX instruction is LB/LH/LW/LBU/LHU
ex_redirect  in  1  EX branch taken or JAL/JALR; PC loads the target next edge
mem_req  in  1  MEM stage has an outstanding load/store
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC register update enable
ifid_en  out  1  IF/ID register load enable
idex_en  out  1  ID/EX register load enable
exmem_en  out  1  EX/MEM register load enable
ifid_flush  out  1  load NOP (0x00000013) into IF/ID
idex_flush  out  1  load NOP into ID/EX
mem_timeout  out  1  sticky: memory wait exceeded TIMEOUT
stall_cycles  out  PERF_W  saturating count of cycles with pc_en=0

Behaviour:
- All state updates happen on the rising edge of clk.
- rst=0 at an edge: state<=RUN, wait_cnt<=0, stall_cycles<=0, mem_timeout<=0. The reset applies mid-wait and from ERROR alike.
- While rst=0, outputs are combinationally forced: all enables=0, ifid_flush=idex_flush=1.
- FSM states, 2-bit encoded in a package enum: RUN, MEM_WAIT, ERROR.
- Outputs are Mealy functions of state and inputs. Zero latency: a hazard visible in a cycle is acted on in that same cycle.
- Load-use hazard: lu = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- mw = mem_req & ~mem_ready.
- RUN, priority mw > ex_redirect > lu:
  - mw: pc_en=ifid_en=idex_en=exmem_en=0, no flush. Next state MEM_WAIT, wait_cnt<=1.
  - ex_redirect: all enables=1, ifid_flush=idex_flush=1. Redirect beats load-use because the ID instruction is squashed, so no stall occurs.
  - lu: pc_en=ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1. Exactly one bubble. The load moves to MEM, so lu clears the next cycle.
  - otherwise: all enables=1, no flush.
- MEM_WAIT:
  - Whole front of the pipeline frozen (pc/ifid/idex/exmem_en=0).
  - ex_redirect and lu are ignored while frozen. They persist because EX/ID are held, and are serviced on the release cycle.
  - mem_ready=1: release cycle. The RUN rules for ex_redirect/lu apply this same cycle with mw treated as 0. Next state RUN, wait_cnt<=0.
  - mem_ready=0 and wait_cnt==TIMEOUT-1: next state ERROR, mem_timeout<=1.
  - otherwise wait_cnt<=wait_cnt+1.
- ERROR: everything frozen and mem_timeout=1. Only reset exits this state. mem_ready is ignored.
- stall_cycles increments every cycle with rst=1 and pc_en=0. It saturates at all-ones and never wraps.
- mem_req=0 with mem_ready=1 (spurious ready) has no effect.

Decomposition:
- hazard_pkg holds:
  - the state enum;
  - constant NOP_INST=32'h00000013;
  - constants for the load opcode 7'b0000011, JAL 7'b1101111, JALR 7'b1100111 and BRANCH 7'b1100011.
  These are shared with instr_dec users.
- One sub-module, hazard_detect: purely combinational lu computation. It is reusable for a future forwarding unit.
- FSM, counters and output muxing stay in hazard_stall_ctrl.

Test Plan:
1. Load-use: EX=LW x5, ID=ADD x6,x5,x1 (id_use_rs1=1, id_rs1=5, ex_rd=5) -> one cycle with pc_en=0, ifid_en=0, idex_flush=1, then all enables=1. stall_cycles=1.
2. x0 and no-use cases: ex_rd=0 with matching rs1, then rs2 match with id_use_rs2=0 -> no stall in either case, stall_cycles stays 0.
3. Redirect plus load-use in the same cycle: ex_redirect=1, lu=1 -> ifid_flush=idex_flush=1, pc_en=1, no bubble cycle. stall_cycles=0.
4. Memory wait: mem_req=1, mem_ready low for 3 cycles, then high -> 3 cycles with all enables=0, release cycle all enables=1. State returns to RUN, stall_cycles=3.
5. Timeout: mem_req=1, mem_ready=0 for 64 cycles -> ERROR entered after the 64th cycle, mem_timeout=1 and held. rst=0 for one edge -> RUN, mem_timeout=0, stall_cycles=0.
6. Deferred redirect: ex_redirect=1 arrives during MEM_WAIT -> no flush while waiting. On the mem_ready cycle ifid_flush=idex_flush=1 and pc_en=1.
